// File: rtl/dma_desc_sched.sv
// Round-robin scheduler sharing one DMA engine among NUM_REQ descriptor requesters.
// Define DMA_SCHED_PRIO_EN to give requester 0 fixed highest priority over the round-robin group.
module dma_desc_sched #(
    parameter int NUM_REQ = 2,
    parameter int DESC_W  = 96,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    input  logic [NUM_REQ*DESC_W-1:0] req_desc_i,
    output logic [NUM_REQ-1:0]        cmpl_valid_o,
    output logic                      cmpl_error_o,
    output logic                      dma_desc_valid_o,
    input  logic                      dma_desc_ready_i,
    output logic [DESC_W-1:0]         dma_desc_o,
    input  logic                      dma_done_i,
    input  logic                      dma_error_i,
    output logic                      busy_o,
    output logic [ID_W-1:0]           grant_id_o
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ID_W-1:0]     rr_ptr;
    logic [ID_W-1:0]     grant_id;
    logic [ID_W-1:0]     winner;
    logic                win_found;
    logic                accept;
    logic                err_q;
    logic [DESC_W-1:0]   desc_q;
    logic [DESC_W-1:0]   win_desc;

    // Descending scan so the valid requester closest above rr_ptr is the one left standing.
    always_comb begin
        winner    = '0;
        win_found = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
`ifdef DMA_SCHED_PRIO_EN
            if (((int'(rr_ptr) + i) % NUM_REQ) != 0 &&
                req_valid_i[(int'(rr_ptr) + i) % NUM_REQ]) begin
`else
            if (req_valid_i[(int'(rr_ptr) + i) % NUM_REQ]) begin
`endif
                winner    = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
                win_found = 1'b1;
            end
        end
`ifdef DMA_SCHED_PRIO_EN
        if (req_valid_i[0]) begin
            winner    = '0;
            win_found = 1'b1;
        end
`endif
    end

    assign win_desc = req_desc_i[int'(winner) * DESC_W +: DESC_W];

    always_comb begin
        state_nxt        = state;
        accept           = 1'b0;
        req_ready_o      = '0;
        dma_desc_valid_o = 1'b0;
        cmpl_valid_o     = '0;
        cmpl_error_o     = 1'b0;
        case (state)
            IDLE: begin
                if (win_found && !rst) begin
                    req_ready_o[winner] = 1'b1;
                    accept              = 1'b1;
                    // Zero-length descriptors complete without ever touching the engine.
                    state_nxt           = (win_desc[63:32] == 32'd0) ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                dma_desc_valid_o = 1'b1;
                if (dma_desc_ready_i) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (dma_error_i || dma_done_i) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                cmpl_valid_o[grant_id] = 1'b1;
                cmpl_error_o           = err_q;
                state_nxt              = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
            desc_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                desc_q   <= win_desc;
                grant_id <= winner;
                err_q    <= 1'b0;
`ifdef DMA_SCHED_PRIO_EN
                if (winner != '0) begin
                    rr_ptr <= ID_W'((int'(winner) + 1) % NUM_REQ);
                end
`else
                rr_ptr <= ID_W'((int'(winner) + 1) % NUM_REQ);
`endif
            end
            if (state == WAIT && (dma_error_i || dma_done_i)) begin
                err_q <= dma_error_i;
            end
        end
    end

    assign dma_desc_o = desc_q;
    assign busy_o     = (state != IDLE);
    assign grant_id_o = grant_id;

endmodule

// File: tb/tb_dma_desc_sched.sv
// Randomized self-checking bench for dma_desc_sched against a transfer-level reference model.
module tb_dma_desc_sched;

    localparam int NUM_REQ = 2;
    localparam int DESC_W  = 96;
    localparam int ID_W    = 1;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DESC_W-1:0] req_desc;
    logic [NUM_REQ-1:0]        cmpl_valid;
    logic                      cmpl_error;
    logic                      dma_desc_valid;
    logic                      dma_desc_ready;
    logic [DESC_W-1:0]         dma_desc;
    logic                      dma_done;
    logic                      dma_error;
    logic                      busy;
    logic [ID_W-1:0]           grant_id;

    int checks   = 0;
    int failures = 0;
    int model_ptr = 0;
    logic [DESC_W-1:0] descs [NUM_REQ];

    always #5 clk = ~clk;

    dma_desc_sched #(.NUM_REQ(NUM_REQ), .DESC_W(DESC_W), .ID_W(ID_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid_i      (req_valid),
        .req_ready_o      (req_ready),
        .req_desc_i       (req_desc),
        .cmpl_valid_o     (cmpl_valid),
        .cmpl_error_o     (cmpl_error),
        .dma_desc_valid_o (dma_desc_valid),
        .dma_desc_ready_i (dma_desc_ready),
        .dma_desc_o       (dma_desc),
        .dma_done_i       (dma_done),
        .dma_error_i      (dma_error),
        .busy_o           (busy),
        .grant_id_o       (grant_id)
    );

    // Arbitration rule: first valid requester at or above the pointer, wrapping around.
    function automatic int exp_winner(input logic [NUM_REQ-1:0] v, input int ptr);
`ifdef DMA_SCHED_PRIO_EN
        if (v[0]) return 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (((ptr + i) % NUM_REQ) != 0 && v[(ptr + i) % NUM_REQ]) return (ptr + i) % NUM_REQ;
        end
`else
        for (int i = 0; i < NUM_REQ; i++) begin
            if (v[(ptr + i) % NUM_REQ]) return (ptr + i) % NUM_REQ;
        end
`endif
        return -1;
    endfunction

    function automatic int next_ptr(input int w, input int ptr);
`ifdef DMA_SCHED_PRIO_EN
        if (w == 0) return ptr;
`endif
        return (w + 1) % NUM_REQ;
    endfunction

    function automatic logic [DESC_W-1:0] rand_desc(input bit zero_len);
        logic [31:0] n;
        n = zero_len ? 32'd0 : 32'($urandom_range(1, 4096));
        return {32'($urandom()), n, 32'($urandom())};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_quiet();
        req_valid      = '0;
        dma_desc_ready = 1'b0;
        dma_done       = 1'b0;
        dma_error      = 1'b0;
    endtask

    // One full request -> completion cycle, checked step by step against the model.
    task automatic run_transfer(input logic [NUM_REQ-1:0] vmask, input int zero_req,
                                input int rdy_dly, input int done_dly,
                                input bit do_err, input bit do_both);
        int                 w;
        logic [NUM_REQ-1:0] oh;
        logic [DESC_W-1:0]  exp_desc;
        bit                 exp_err;
        for (int r = 0; r < NUM_REQ; r++) begin
            descs[r] = rand_desc(r == zero_req);
            req_desc[r*DESC_W +: DESC_W] = descs[r];
        end
        req_valid = vmask;
        #1;
        w  = exp_winner(vmask, model_ptr);
        oh = '0;
        oh[w] = 1'b1;
        exp_desc = descs[w];
        checks++;
        if (req_ready !== oh) begin
            failures++;
            $display("[TB] FAIL req_ready: got %b want %b", req_ready, oh);
        end
        tick();
        req_valid = '0;
        for (int r = 0; r < NUM_REQ; r++) req_desc[r*DESC_W +: DESC_W] = rand_desc(1'b0);
        model_ptr = next_ptr(w, model_ptr);
        checks++;
        if (grant_id !== ID_W'(w) || busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL grant: got id=%0d busy=%b want id=%0d busy=1", grant_id, busy, w);
        end
        if (exp_desc[63:32] == 32'd0) begin
            checks++;
            if (cmpl_valid !== oh || cmpl_error !== 1'b0 || dma_desc_valid !== 1'b0) begin
                failures++;
                $display("[TB] FAIL zero_len: got cmpl=%b err=%b dvalid=%b want cmpl=%b err=0 dvalid=0",
                         cmpl_valid, cmpl_error, dma_desc_valid, oh);
            end
            tick();
            checks++;
            if (cmpl_valid !== '0 || busy !== 1'b0) begin
                failures++;
                $display("[TB] FAIL zero_len_end: got cmpl=%b busy=%b want 0 0", cmpl_valid, busy);
            end
            return;
        end
        for (int k = 0; k <= rdy_dly; k++) begin
            checks++;
            if (dma_desc_valid !== 1'b1 || dma_desc !== exp_desc) begin
                failures++;
                $display("[TB] FAIL issue[%0d]: got valid=%b desc=%h want valid=1 desc=%h",
                         k, dma_desc_valid, dma_desc, exp_desc);
            end
            dma_desc_ready = (k == rdy_dly);
            tick();
        end
        dma_desc_ready = 1'b0;
        exp_err = do_err || do_both;
        for (int k = 0; k <= done_dly; k++) begin
            checks++;
            if (dma_desc_valid !== 1'b0 || cmpl_valid !== '0) begin
                failures++;
                $display("[TB] FAIL wait[%0d]: got valid=%b cmpl=%b want 0 0", k, dma_desc_valid, cmpl_valid);
            end
            dma_done  = (k == done_dly) && (!do_err || do_both);
            dma_error = (k == done_dly) && exp_err;
            tick();
        end
        dma_done  = 1'b0;
        dma_error = 1'b0;
        req_valid = vmask;
        #1;
        checks++;
        if (cmpl_valid !== oh || cmpl_error !== exp_err || req_ready !== '0) begin
            failures++;
            $display("[TB] FAIL resp: got cmpl=%b err=%b ready=%b want cmpl=%b err=%b ready=0",
                     cmpl_valid, cmpl_error, req_ready, oh, exp_err);
        end
        req_valid = '0;
        tick();
        checks++;
        if (cmpl_valid !== '0 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL resp_end: got cmpl=%b busy=%b want 0 0", cmpl_valid, busy);
        end
    endtask

    task automatic test_reset();
        drive_quiet();
        req_desc = '0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        model_ptr = 0;
        #1;
        checks++;
        if (busy !== 1'b0 || req_ready !== '0 || cmpl_valid !== '0 || cmpl_error !== 1'b0 ||
            dma_desc_valid !== 1'b0 || dma_desc !== '0 || grant_id !== '0) begin
            failures++;
            $display("[TB] FAIL reset: got busy=%b ready=%b cmpl=%b err=%b dvalid=%b desc=%h id=%0d want all 0",
                     busy, req_ready, cmpl_valid, cmpl_error, dma_desc_valid, dma_desc, grant_id);
        end
    endtask

    task automatic test_single();
        run_transfer(2'b01, -1, 0, 4, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int t = 0; t < 4; t++) run_transfer(2'b11, -1, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_zero_len();
        run_transfer(2'b10, 1, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_ready_stall();
        run_transfer(2'b11, -1, 10, 1, 1'b0, 1'b0);
    endtask

    task automatic test_error_priority();
        run_transfer(2'b11, -1, 1, 2, 1'b0, 1'b1);
        run_transfer(2'b10, -1, 0, 0, 1'b1, 1'b0);
    endtask

    task automatic test_stray_done();
        dma_done  = 1'b1;
        dma_error = 1'b1;
        tick();
        dma_done  = 1'b0;
        dma_error = 1'b0;
        checks++;
        if (cmpl_valid !== '0 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL stray_done: got cmpl=%b busy=%b want 0 0", cmpl_valid, busy);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 12; t++) begin
            run_transfer(NUM_REQ'($urandom_range(1, 3)),
                         ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 1)) : -1,
                         int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_reset_mid();
        req_desc[0 +: DESC_W] = rand_desc(1'b0);
        req_valid = 2'b01;
        tick();
        req_valid = '0;
        dma_desc_ready = 1'b1;
        tick();
        dma_desc_ready = 1'b0;
        checks++;
        if (busy !== 1'b1 || dma_desc_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reach_wait: got busy=%b dvalid=%b want 1 0", busy, dma_desc_valid);
        end
        rst      = 1'b1;
        dma_done = 1'b1;
        tick();
        rst      = 1'b0;
        dma_done = 1'b0;
        model_ptr = 0;
        checks++;
        if (busy !== 1'b0 || dma_desc_valid !== 1'b0 || dma_desc !== '0 || cmpl_valid !== '0 ||
            cmpl_error !== 1'b0 || grant_id !== '0) begin
            failures++;
            $display("[TB] FAIL reset_mid: got busy=%b dvalid=%b desc=%h cmpl=%b err=%b id=%0d want all 0",
                     busy, dma_desc_valid, dma_desc, cmpl_valid, cmpl_error, grant_id);
        end
        tick();
        checks++;
        if (cmpl_valid !== '0) begin
            failures++;
            $display("[TB] FAIL reset_mid_pulse: got cmpl=%b want 00", cmpl_valid);
        end
        run_transfer(2'b11, -1, 0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        drive_quiet();
        req_desc = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_zero_len();
        test_ready_stall();
        test_error_priority();
        test_stray_done();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
